// File: rtl/pipe_pkg.sv
// Shared width defaults and state encoding for the EX/MEM elastic pipeline stage.
package pipe_pkg;

   localparam int DEF_DATAPATH_WIDTH     = 64;
   localparam int DEF_REGFILE_ADDR_WIDTH = 5;
   localparam int DEF_INST_ADDR_WIDTH    = 9;
   localparam int DEF_CTRL_WIDTH         = 2;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } pipe_state_e;

endpackage

// File: rtl/pipe_payload_reg.sv
// Width-parametrised payload register with load enable and synchronous active-low clear.
module pipe_payload_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Payload storage: clears to zero, otherwise only changes on load
   always_ff @(posedge clk) begin
      if (!clear_n) begin
         q <= {WIDTH{1'b0}};
      end else if (load) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/pipe_exmem_elastic.sv
// EX/MEM 2-entry elastic buffer: main register feeds MEM, skid register absorbs one stalled beat.
module pipe_exmem_elastic
   import pipe_pkg::*;
#(
   parameter int DATAPATH_WIDTH     = DEF_DATAPATH_WIDTH,
   parameter int REGFILE_ADDR_WIDTH = DEF_REGFILE_ADDR_WIDTH,
   parameter int INST_ADDR_WIDTH    = DEF_INST_ADDR_WIDTH,
   parameter int CTRL_WIDTH         = DEF_CTRL_WIDTH
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [INST_ADDR_WIDTH-1:0]    pc_in,
   input  logic [DATAPATH_WIDTH-1:0]     accum_in,
   input  logic [DATAPATH_WIDTH-1:0]     store_data_in,
   input  logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_in,
   input  logic [CTRL_WIDTH-1:0]         ctrl_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [INST_ADDR_WIDTH-1:0]    pc_out,
   output logic [DATAPATH_WIDTH-1:0]     accum_out,
   output logic [DATAPATH_WIDTH-1:0]     store_data_out,
   output logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_out,
   output logic [CTRL_WIDTH-1:0]         ctrl_out,
   output logic [1:0]                    occupancy
);

   localparam int PAYLOAD_W = INST_ADDR_WIDTH + 2 * DATAPATH_WIDTH + REGFILE_ADDR_WIDTH + CTRL_WIDTH;

   pipe_state_e          state_r;
   pipe_state_e          state_nxt_s;
   logic                 main_load_s;
   logic                 skid_load_s;
   logic                 main_from_skid_s;
   logic [PAYLOAD_W-1:0] in_payload_s;
   logic [PAYLOAD_W-1:0] main_d_s;
   logic [PAYLOAD_W-1:0] main_q_s;
   logic [PAYLOAD_W-1:0] skid_q_s;

   assign in_payload_s = {pc_in, accum_in, store_data_in, WR_addr_in, ctrl_in};
   assign main_d_s     = main_from_skid_s ? skid_q_s : in_payload_s;
   assign {pc_out, accum_out, store_data_out, WR_addr_out, ctrl_out} = main_q_s;

   // Next-state and load decode; flush wins over every handshake and blocks all loads
   always_comb begin
      state_nxt_s      = state_r;
      main_load_s      = 1'b0;
      skid_load_s      = 1'b0;
      main_from_skid_s = 1'b0;
      if (flush) begin
         state_nxt_s = EMPTY;
      end else begin
         case (state_r)
            EMPTY: begin
               if (in_valid) begin
                  main_load_s = 1'b1;
                  state_nxt_s = ONE;
               end else begin
                  state_nxt_s = EMPTY;
               end
            end
            ONE: begin
               if (in_valid && out_ready) begin
                  main_load_s = 1'b1;
                  state_nxt_s = ONE;
               end else if (in_valid) begin
                  skid_load_s = 1'b1;
                  state_nxt_s = FULL;
               end else if (out_ready) begin
                  state_nxt_s = EMPTY;
               end else begin
                  state_nxt_s = ONE;
               end
            end
            FULL: begin
               if (out_ready) begin
                  main_load_s      = 1'b1;
                  main_from_skid_s = 1'b1;
                  state_nxt_s      = ONE;
               end else begin
                  state_nxt_s = FULL;
               end
            end
            default: begin
               state_nxt_s = EMPTY;
            end
         endcase
      end
   end

   // State plus registered handshake/occupancy outputs, so out_ready never reaches in_ready
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r   <= EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         occupancy <= 2'd0;
      end else begin
         state_r   <= state_nxt_s;
         out_valid <= (state_nxt_s != EMPTY);
         in_ready  <= (state_nxt_s != FULL);
         occupancy <= state_nxt_s;
      end
   end

   pipe_payload_reg #(.WIDTH(PAYLOAD_W)) u_main (
      .clk     (clk),
      .clear_n (reset_n),
      .load    (main_load_s),
      .d       (main_d_s),
      .q       (main_q_s)
   );

   pipe_payload_reg #(.WIDTH(PAYLOAD_W)) u_skid (
      .clk     (clk),
      .clear_n (reset_n),
      .load    (skid_load_s),
      .d       (in_payload_s),
      .q       (skid_q_s)
   );

endmodule

// File: tb/tb_pipe_exmem_elastic.sv
// Scoreboard bench for pipe_exmem_elastic: directed reset/stream/backpressure/flush/reset cases plus random handshakes.
module tb_pipe_exmem_elastic;

   typedef struct packed {
      logic [8:0]  pc;
      logic [63:0] acc;
      logic [63:0] sd;
      logic [4:0]  wa;
      logic [1:0]  ctrl;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [8:0]  pc_in = 9'd0;
   logic [63:0] accum_in = 64'd0;
   logic [63:0] store_data_in = 64'd0;
   logic [4:0]  WR_addr_in = 5'd0;
   logic [1:0]  ctrl_in = 2'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [8:0]  pc_out;
   logic [63:0] accum_out;
   logic [63:0] store_data_out;
   logic [4:0]  WR_addr_out;
   logic [1:0]  ctrl_out;
   logic [1:0]  occupancy;

   int    n_cmp = 0;
   int    n_bad = 0;
   beat_t exp_q[$];

   pipe_exmem_elastic dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .pc_in          (pc_in),
      .accum_in       (accum_in),
      .store_data_in  (store_data_in),
      .WR_addr_in     (WR_addr_in),
      .ctrl_in        (ctrl_in),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .pc_out         (pc_out),
      .accum_out      (accum_out),
      .store_data_out (store_data_out),
      .WR_addr_out    (WR_addr_out),
      .ctrl_out       (ctrl_out),
      .occupancy      (occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs just after a rising edge, then step to just after the next one
   task automatic cyc(input logic v, input logic [8:0] p, input logic [63:0] a,
                      input logic ordy, input logic fl, input logic rn);
      in_valid      = v;
      pc_in         = p;
      accum_in      = a;
      store_data_in = ~a;
      WR_addr_in    = p[4:0];
      ctrl_in       = p[1:0];
      out_ready     = ordy;
      flush         = fl;
      reset_n       = rn;
      @(posedge clk);
      #1;
   endtask

   // Monitor: on the falling edge, check handshake outputs against the model, pop on transfer out,
   // then advance the model with the inputs the coming rising edge will sample
   always @(negedge clk) begin
      beat_t e;
      int    cnt;
      cnt = exp_q.size();
      if (reset_n === 1'b1) begin
         chk("out_valid", 64'(out_valid), 64'(cnt != 0));
         chk("in_ready", 64'(in_ready), 64'(cnt != 2));
         chk("occupancy", 64'(occupancy), 64'(cnt));
         if (cnt != 0 && out_ready) begin
            e = exp_q.pop_front();
            chk("sb_pc", 64'(pc_out), 64'(e.pc));
            chk("sb_accum", accum_out, e.acc);
            chk("sb_store", store_data_out, e.sd);
            chk("sb_wr_addr", 64'(WR_addr_out), 64'(e.wa));
            chk("sb_ctrl", 64'(ctrl_out), 64'(e.ctrl));
         end
      end
      if (reset_n !== 1'b1 || flush) begin
         exp_q.delete();
      end else if (in_valid && cnt != 2) begin
         e.pc   = pc_in;
         e.acc  = accum_in;
         e.sd   = store_data_in;
         e.wa   = WR_addr_in;
         e.ctrl = ctrl_in;
         exp_q.push_back(e);
      end
   end

   initial begin
      // Reset held two cycles with in_valid asserted
      cyc(1'b1, 9'd33, 64'hDEAD, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 9'd34, 64'hBEEF, 1'b0, 1'b0, 1'b0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_occupancy", 64'(occupancy), 64'd0);
      chk("rst_pc", 64'(pc_out), 64'd0);
      chk("rst_accum", accum_out, 64'd0);
      chk("rst_store", store_data_out, 64'd0);
      chk("rst_wr_addr", 64'(WR_addr_out), 64'd0);
      chk("rst_ctrl", 64'(ctrl_out), 64'd0);

      // Streaming pc 1..8, accum 0x10..0x80: each visible one cycle later, no bubbles
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b1, 9'(i), 64'(16 * i), 1'b1, 1'b0, 1'b1);
         chk("stream_pc", 64'(pc_out), 64'(i));
         chk("stream_accum", accum_out, 64'(16 * i));
         chk("stream_valid", 64'(out_valid), 64'd1);
      end
      cyc(1'b0, 9'd0, 64'd0, 1'b1, 1'b0, 1'b1);
      chk("stream_drained", 64'(occupancy), 64'd0);

      // Backpressure: A (pc 5) then B (pc 6) with out_ready low
      cyc(1'b1, 9'd5, 64'h55, 1'b0, 1'b0, 1'b1);
      chk("bp_a_pc", 64'(pc_out), 64'd5);
      cyc(1'b1, 9'd6, 64'h66, 1'b0, 1'b0, 1'b1);
      chk("bp_full_occ", 64'(occupancy), 64'd2);
      chk("bp_full_rdy", 64'(in_ready), 64'd0);
      chk("bp_full_pc", 64'(pc_out), 64'd5);
      cyc(1'b1, 9'd99, 64'h99, 1'b0, 1'b0, 1'b1);
      chk("bp_hold_pc", 64'(pc_out), 64'd5);
      chk("bp_hold_accum", accum_out, 64'h55);
      cyc(1'b0, 9'd0, 64'd0, 1'b1, 1'b0, 1'b1);
      chk("bp_pop1_pc", 64'(pc_out), 64'd6);
      chk("bp_pop1_occ", 64'(occupancy), 64'd1);
      cyc(1'b0, 9'd0, 64'd0, 1'b1, 1'b0, 1'b1);
      chk("bp_pop2_occ", 64'(occupancy), 64'd0);

      // Flush while FULL with pc 7 offered; payload holds the old main value
      cyc(1'b1, 9'd3, 64'h33, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 9'd4, 64'h44, 1'b0, 1'b0, 1'b1);
      chk("fl_pre_occ", 64'(occupancy), 64'd2);
      cyc(1'b1, 9'd7, 64'h77, 1'b0, 1'b1, 1'b1);
      chk("fl_valid", 64'(out_valid), 64'd0);
      chk("fl_occ", 64'(occupancy), 64'd0);
      chk("fl_pc_hold", 64'(pc_out), 64'd3);
      cyc(1'b0, 9'd0, 64'd0, 1'b1, 1'b0, 1'b1);
      chk("fl_after_valid", 64'(out_valid), 64'd0);

      // Reset in FULL with out_ready high in the same cycle
      cyc(1'b1, 9'd8, 64'h88, 1'b0, 1'b0, 1'b1);
      cyc(1'b1, 9'd9, 64'h99, 1'b0, 1'b0, 1'b1);
      chk("rf_pre_occ", 64'(occupancy), 64'd2);
      cyc(1'b1, 9'd10, 64'hAA, 1'b1, 1'b0, 1'b0);
      chk("rf_valid", 64'(out_valid), 64'd0);
      chk("rf_occ", 64'(occupancy), 64'd0);
      chk("rf_pc", 64'(pc_out), 64'd0);
      cyc(1'b0, 9'd0, 64'd0, 1'b1, 1'b0, 1'b1);
      chk("rf_after_valid", 64'(out_valid), 64'd0);

      // Random in_valid/out_ready, checked entirely by the scoreboard monitor
      for (int i = 0; i < 10000; i++) begin
         in_valid      = 1'($urandom_range(0, 1));
         pc_in         = 9'(i);
         accum_in      = {$urandom, $urandom};
         store_data_in = {$urandom, $urandom};
         WR_addr_in    = 5'($urandom);
         ctrl_in       = 2'($urandom);
         out_ready     = 1'($urandom_range(0, 1));
         flush         = 1'b0;
         reset_n       = 1'b1;
         @(posedge clk);
         #1;
      end
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 9'd0, 64'd0, 1'b1, 1'b0, 1'b1);
      end
      chk("final_occ", 64'(occupancy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
